// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg
// Shared constants for the operand loader: word/operand geometry, the
// operand slot order on the input stream, and the loader state encoding.
package operand_loader_pkg;

  localparam int WORD_W      = 64;
  localparam int OP_WORDS    = 16;
  localparam int N_OPS       = 5;
  localparam int OP_W        = WORD_W * OP_WORDS;
  localparam int TOTAL_WORDS = OP_WORDS * N_OPS;

  // Operand slots, in the order they arrive on the word stream.
  localparam int OP_X  = 0;
  localparam int OP_M  = 1;
  localparam int OP_E  = 2;
  localparam int OP_R  = 3;
  localparam int OP_R2 = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_START,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/operand_loader_msb.sv
// msb_find64
// Combinational priority encoder: reports whether a word is nonzero and
// the bit position of its most significant set bit.
// Ports:
//   word     in   WORD_W   word under test
//   nonzero  out  1        any bit of word set
//   pos      out  6        index of the highest set bit (0 when word == 0)
module msb_find64
  import operand_loader_pkg::*;
(
  input  logic [WORD_W-1:0]         word,
  output logic                      nonzero,
  output logic [$clog2(WORD_W)-1:0] pos
);

  always_comb begin
    nonzero = |word;
    pos     = '0;
    // Ascending scan: the last set bit seen is the most significant one.
    for (int i = 0; i < WORD_W; i++) begin
      if (word[i]) pos = ($clog2(WORD_W))'(i);
    end
  end

endmodule

// File: rtl/operand_loader.sv
// operand_loader
// Collects five 1024-bit operands (x, m, e, r, r2) from a 64-bit
// valid/ready word stream, measures the bit length of e, and launches the
// ladder with a one-cycle start pulse. A zero exponent is reported with
// err_zero instead of a launch.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     word handshake, in_data carries the word
//   out_x..out_r2         assembled operands (registered)
//   lene                  bit length of e (registered)
//   start                 one-cycle ladder launch
//   ladder_done           ladder completion pulse (used only in WAIT)
//   done                  one-cycle job-complete pulse
//   err_zero              one-cycle pulse when e == 0
//
// state  | meaning
// IDLE   | waiting for the first word of a job
// LOAD   | accepting words 1..79
// SCAN   | searching e for its top nonzero word, word 15 downwards
// START  | start pulse to the ladder
// WAIT   | waiting for ladder_done
module operand_loader #(
  parameter int WORD_W   = operand_loader_pkg::WORD_W,
  parameter int OP_WORDS = operand_loader_pkg::OP_WORDS,
  parameter int N_OPS    = operand_loader_pkg::N_OPS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_data,
  output logic [WORD_W*OP_WORDS-1:0] out_x,
  output logic [WORD_W*OP_WORDS-1:0] out_m,
  output logic [WORD_W*OP_WORDS-1:0] out_e,
  output logic [WORD_W*OP_WORDS-1:0] out_r,
  output logic [WORD_W*OP_WORDS-1:0] out_r2,
  output logic [31:0]                lene,
  output logic                       start,
  input  logic                       ladder_done,
  output logic                       done,
  output logic                       err_zero
);

  import operand_loader_pkg::*;

  localparam int OPND_W = WORD_W * OP_WORDS;
  localparam int LAST_G = OP_WORDS * N_OPS - 1;
  localparam int CW     = $clog2(OP_WORDS * N_OPS);
  localparam int PW     = $clog2(OP_WORDS);
  localparam int POS_W  = $clog2(WORD_W);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     ptr;
  logic [OPND_W-1:0] ops [N_OPS];
  logic              xfer;
  logic [WORD_W-1:0] e_word;
  logic              e_nz;
  logic [POS_W-1:0]  e_pos;

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start     = 1'b0;
    err_zero  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = !reset;
        if (in_valid && !reset && cnt == CW'(LAST_G)) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (e_nz) begin
          state_nxt = ST_START;
        end else if (ptr == '0) begin
          err_zero  = !reset;
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        start     = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ladder_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Word of e currently under test.
  always_comb begin
    e_word = '0;
    for (int j = 0; j < OP_WORDS; j++) begin
      if (ptr == PW'(j)) e_word = ops[OP_E][j*WORD_W +: WORD_W];
    end
  end

  msb_find64 u_msb (
    .word    (e_word),
    .nonzero (e_nz),
    .pos     (e_pos)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      ptr  <= '0;
      lene <= '0;
      done <= 1'b0;
      for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
    end else begin
      done <= (state == ST_WAIT) && ladder_done;

      if (xfer) begin
        // Counter value g selects operand g/OP_WORDS, word g%OP_WORDS.
        for (int i = 0; i < N_OPS; i++) begin
          for (int j = 0; j < OP_WORDS; j++) begin
            if (cnt == CW'(i*OP_WORDS + j)) ops[i][j*WORD_W +: WORD_W] <= in_data;
          end
        end
        if (cnt == CW'(LAST_G)) begin
          cnt <= '0;
          ptr <= PW'(OP_WORDS - 1);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (state == ST_SCAN) begin
        if (e_nz)             lene <= 32'(ptr) * 32'(WORD_W) + 32'(e_pos) + 32'd1;
        else if (ptr == '0)   lene <= '0;
        else                  ptr  <= ptr - 1'b1;
      end
    end
  end

  assign out_x  = ops[OP_X];
  assign out_m  = ops[OP_M];
  assign out_e  = ops[OP_E];
  assign out_r  = ops[OP_R];
  assign out_r2 = ops[OP_R2];

endmodule
